// File: rtl/shiftreg_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with a runtime-selectable output tap and a valid tag per word.
// Supports shift, rotate (recirculate through the tapped loop), hold and synchronous clear.
module shiftreg_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int TAP_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [TAP_W-1:0] tap,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             primed
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_t;

  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  mode_t            mode_sel;
  logic             clear_now;
  logic             move_now;
  logic             rotate_now;
  logic [TAP_W-1:0] tap_eff;

  logic [WIDTH-1:0] stage_reg [DEPTH];
  logic [DEPTH-1:0] vld_reg;
  logic [CNT_W-1:0] fill_reg;
  logic [CNT_W-1:0] fill_next;
  logic [WIDTH-1:0] stage0_next;
  logic             vld0_next;

  assign mode_sel   = mode_t'(mode);
  assign clear_now  = rst || (mode_sel == MODE_CLEAR);
  assign move_now   = en && ((mode_sel == MODE_SHIFT) || (mode_sel == MODE_ROTATE));
  assign rotate_now = (mode_sel == MODE_ROTATE);

  // Out-of-range taps can only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << TAP_W)) begin : g_tap_direct
      assign tap_eff = tap;
    end else begin : g_tap_clamp
      assign tap_eff = (tap > TAP_MAX) ? TAP_MAX : tap;
    end
  endgenerate

  always_comb begin
    stage0_next = din;
    vld0_next   = din_valid;
    if (rotate_now) begin
      stage0_next = stage_reg[tap_eff];
      vld0_next   = vld_reg[tap_eff];
    end
  end

  // Only plain shifts count toward fill; rotation just recirculates existing words.
  always_comb begin
    fill_next = fill_reg;
    if (en && (mode_sel == MODE_SHIFT) && (fill_reg != FILL_MAX)) begin
      fill_next = fill_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_now) begin
      stage_reg[0] <= '0;
      vld_reg[0]   <= 1'b0;
      fill_reg     <= '0;
    end else if (move_now) begin
      stage_reg[0] <= stage0_next;
      vld_reg[0]   <= vld0_next;
      fill_reg     <= fill_next;
    end
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (clear_now) begin
          stage_reg[gi] <= '0;
          vld_reg[gi]   <= 1'b0;
        end else if (move_now) begin
          stage_reg[gi] <= stage_reg[gi-1];
          vld_reg[gi]   <= vld_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout       = stage_reg[tap_eff];
  assign dout_valid = vld_reg[tap_eff];
  assign fill_cnt   = fill_reg;
  assign primed     = (fill_reg > CNT_W'(tap_eff));

endmodule

// File: tb/tb_shiftreg_delay_line.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model
// (newest word at the front, the word at index k has been shifted k+1 times).
module tb_shiftreg_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int TAP_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b10;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic [TAP_W-1:0] tap = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CNT_W-1:0] fill_cnt;
  logic             primed;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_data[$];
  logic             m_vld[$];
  int               m_fill;

  shiftreg_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAP_W(TAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .tap(tap), .dout(dout), .dout_valid(dout_valid), .fill_cnt(fill_cnt), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tap_eff_of(input logic [TAP_W-1:0] t);
    return (int'(t) > DEPTH - 1) ? DEPTH - 1 : int'(t);
  endfunction

  task automatic model_clear();
    m_data = {};
    m_vld  = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_data.push_back('0);
      m_vld.push_back(1'b0);
    end
    m_fill = 0;
  endtask

  task automatic check_outputs(input string tag);
    int t;
    t = tap_eff_of(tap);
    check({tag, "_dout"},   32'(dout),       32'(m_data[t]));
    check({tag, "_dvld"},   32'(dout_valid), 32'(m_vld[t]));
    check({tag, "_fill"},   32'(fill_cnt),   32'(m_fill));
    check({tag, "_primed"}, 32'(primed),     32'(m_fill > t));
  endtask

  // Apply one clock edge with the given controls, advance the model, then compare.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                      input logic [WIDTH-1:0] d, input logic dv);
    logic [WIDTH-1:0] w;
    logic             wv;
    int               t;
    rst = r; en = e; mode = m; din = d; din_valid = dv;
    t = tap_eff_of(tap);
    @(posedge clk);
    if (r || m == 2'b11) begin
      model_clear();
    end else if (e && (m == 2'b00 || m == 2'b01)) begin
      w  = (m == 2'b00) ? d  : m_data[t];
      wv = (m == 2'b00) ? dv : m_vld[t];
      m_data.push_front(w);
      m_vld.push_front(wv);
      void'(m_data.pop_back());
      void'(m_vld.pop_back());
      if (m == 2'b00 && m_fill < DEPTH) m_fill++;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_clear();
    // Reset state
    step("rst", 1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
    step("rst", 1'b1, 1'b1, 2'b00, 8'hff, 1'b1);
    check("rst_dout0", 32'(dout), 32'h0);

    // Scenario 1: tap=3, shift 1..10
    tap = 3;
    for (int i = 1; i <= 10; i++) begin
      step("s1", 1'b0, 1'b1, 2'b00, 8'(i), 1'b1);
      if (i == 3) check("s1_not_primed", 32'(primed), 32'h0);
      if (i == 4) begin
        check("s1_first", 32'(dout), 32'h1);
        check("s1_primed", 32'(primed), 32'h1);
      end
      if (i == 10) check("s1_last", 32'(dout), 32'h7);
    end

    // Scenario 2: full depth latency and fill saturation
    step("s2rst", 1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
    tap = TAP_W'(DEPTH - 1);
    for (int i = 1; i <= 100; i++) begin
      step("s2", 1'b0, 1'b1, 2'b00, (i == 1) ? 8'ha5 : 8'h00, 1'b1);
      if (i == DEPTH - 1) check("s2_early", 32'(dout), 32'h0);
      if (i == DEPTH)     check("s2_a5", 32'(dout), 32'ha5);
    end
    check("s2_sat", 32'(fill_cnt), 32'(DEPTH));

    // Scenario 3: rotate a 3-word loop, din ignored
    step("s3rst", 1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
    tap = 2;
    step("s3", 1'b0, 1'b1, 2'b00, 8'h11, 1'b1);
    step("s3", 1'b0, 1'b1, 2'b00, 8'h22, 1'b1);
    step("s3", 1'b0, 1'b1, 2'b00, 8'h33, 1'b1);
    check("s3_pre", 32'(dout), 32'h11);
    for (int i = 0; i < 6; i++) step("s3rot", 1'b0, 1'b1, 2'b01, 8'hee, 1'b0);
    check("s3_fill", 32'(fill_cnt), 32'd3);
    check("s3_loop", 32'(dout), 32'h11);

    // Scenario 4: freeze via en=0 and HOLD, then resume
    step("s4rst", 1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
    tap = 1;
    for (int i = 0; i < 4; i++) step("s4a", 1'b0, 1'b1, 2'b00, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 5; i++) step("s4en", 1'b0, 1'b0, 2'b00, 8'hcc, 1'b1);
    for (int i = 0; i < 5; i++) step("s4hold", 1'b0, 1'b1, 2'b10, 8'hdd, 1'b1);
    check("s4_frozen", 32'(dout), 32'h42);
    for (int i = 4; i < 8; i++) step("s4b", 1'b0, 1'b1, 2'b00, 8'(8'h40 + i), 1'b1);
    check("s4_resume", 32'(dout), 32'h46);

    // Scenario 5: CLEAR with en=0 at fill 20, then reset beating SHIFT
    tap = 3;
    step("s5rst", 1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) step("s5", 1'b0, 1'b1, 2'b00, 8'(i + 1), 1'b1);
    check("s5_fill20", 32'(fill_cnt), 32'd20);
    step("s5clr", 1'b0, 1'b0, 2'b11, 8'h77, 1'b1);
    check("s5_clr_fill", 32'(fill_cnt), 32'd0);
    for (int i = 0; i < 20; i++) step("s5", 1'b0, 1'b1, 2'b00, 8'(i + 1), 1'b1);
    step("s5rstsh", 1'b1, 1'b1, 2'b00, 8'h99, 1'b1);
    check("s5_rst_dvld", 32'(dout_valid), 32'd0);

    // Scenario 6: alternating valid, tap change mid-stream
    tap = 5;
    for (int i = 0; i < 12; i++) step("s6", 1'b0, 1'b1, 2'b00, 8'(8'h80 + i), 1'(i % 2 == 0));
    tap = 1;
    #1;
    check_outputs("s6tap");
    check("s6_tap1", 32'(dout), 32'h8a);

    // Random traffic, including out-of-range-free taps, rotates, holds and clears
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] m;
      int         r;
      r = $urandom_range(0, 99);
      m = (r < 55) ? 2'b00 : (r < 75) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 15) == 0) begin
        tap = TAP_W'($urandom_range(0, DEPTH - 1));
        #1;
        check_outputs("rnd_tap");
      end
      step("rnd", 1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 4) != 0), m,
           8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
